// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer writer.
// Holds the FSM state type, the pixels-per-word constant and the gray-to-RGB helper.
package fb_pkg;

  // Writer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } fb_estado_t;

  // Each 32-bit input word carries four 8-bit grayscale pixels.
  localparam int PIX_POR_PALABRA = 4;

  // Expand one grayscale byte into a 24-bit {R,G,B} value with equal channels.
  function automatic logic [23:0] gris_a_rgb(input logic [7:0] gris);
    return {gris, gris, gris};
  endfunction

endpackage

// File: rtl/fifo_palabras.sv
// Synchronous word FIFO between the processor interface and the unpacker.
// Push and pop may occur together even when full: the pop frees the slot
// that the push then fills. Pop on empty is ignored.
module fifo_palabras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

  // Storage write.
  // NOTE: the data array has no reset; the pointers alone define which entries are valid,
  // and leaving it unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end
  end

  // Write and read pointer advance.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/escritor_framebuffer.sv
// Framebuffer writer: drains 32-bit grayscale words (4 pixels each, byte 0 first),
// expands every byte to a gray RGB pixel and writes it to video RAM at a linear
// address 0..FRAME_PIXELS-1, then pulses frame_done.
// Optional build macro FB_VBLANK_GATE_EN adds a vblank input; pixels (and unpacker
// loads) only proceed while vblank=1, so the FIFO fills up and back-pressures.
module escritor_framebuffer
  import fb_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int FRAME_PIXELS = 65536,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
`ifdef FB_VBLANK_GATE_EN
  input  logic              vblank,
`endif
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int                PALABRAS  = FRAME_PIXELS / PIX_POR_PALABRA;
  localparam int                WCNT_W    = $clog2(PALABRAS + 1);
  localparam logic [WCNT_W-1:0] WORD_LIM  = WCNT_W'(PALABRAS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  // Control state.
  fb_estado_t          r_estado;
  logic [WCNT_W-1:0]   r_words_acc;
  logic [ADDR_W-1:0]   r_pix_cnt;
  logic                r_ultimo;

  // Unpacker state.
  logic                r_unp_valid;
  logic [31:0]         r_unp_word;
  logic [1:0]          r_byte_idx;

  // Internal nets.
  logic                w_run;
  logic                w_gate;
  logic                w_room;
  logic                w_push;
  logic                w_pop;
  logic                w_emit;
  logic                w_unp_free;
  logic                w_last_pix;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [31:0]         w_fifo_data;
  logic [7:0]          w_byte;

`ifdef FB_VBLANK_GATE_EN
  // Outside vblank the pixel path freezes the same cycle vblank falls.
  assign w_gate = vblank;
`else
  assign w_gate = 1'b1;
`endif

  assign w_run  = (r_estado == RUN);
  assign w_room = (r_words_acc < WORD_LIM);

  // Input handshake: only in RUN, only with FIFO space, never past the frame's word count.
  assign in_ready = w_run && !w_fifo_full && w_room;
  assign w_push   = in_valid && in_ready;

  // A pixel leaves the unpacker whenever it holds a word and the gate is open.
  assign w_emit     = w_run && w_gate && r_unp_valid;
  assign w_last_pix = w_emit && (r_pix_cnt == LAST_ADDR);

  // The unpacker can take a new word when empty, or on the cycle its last byte leaves,
  // which keeps a steady stream at one pixel per clock.
  assign w_unp_free = !r_unp_valid || (w_emit && (r_byte_idx == 2'd3));
  assign w_pop      = w_run && w_gate && w_unp_free && !w_fifo_empty;

  assign w_byte = r_unp_word[{r_byte_idx, 3'b000} +: 8];

  assign busy       = (r_estado == RUN);
  assign frame_done = (r_estado == FIN);

  fifo_palabras #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Frame FSM: IDLE waits for start, RUN moves pixels, FIN is the one-cycle done pulse.
  // FIN is entered the cycle after the final write strobe, so frame_done trails it by one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado <= IDLE;
      r_ultimo <= 1'b0;
    end else begin
      case (r_estado)
        IDLE: begin
          r_ultimo <= 1'b0;
          if (start) r_estado <= RUN;
        end
        RUN: begin
          r_ultimo <= w_last_pix;
          if (r_ultimo) r_estado <= FIN;
        end
        FIN: begin
          r_ultimo <= 1'b0;
          r_estado <= IDLE;
        end
        default: begin
          r_ultimo <= 1'b0;
          r_estado <= IDLE;
        end
      endcase
    end
  end

  // Accepted-word counter: cleared on frame start, bounds how many words a frame takes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_words_acc <= '0;
    end else if ((r_estado == IDLE) && start) begin
      r_words_acc <= '0;
    end else if (w_push) begin
      r_words_acc <= r_words_acc + 1'b1;
    end
  end

  // Pixel address counter: advances per emitted pixel and wraps after the last address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix_cnt <= '0;
    end else if ((r_estado == IDLE) && start) begin
      r_pix_cnt <= '0;
    end else if (w_emit) begin
      r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
    end
  end

  // Unpacker: load a word from the FIFO head, then step through bytes 0..3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_unp_valid <= 1'b0;
      r_unp_word  <= '0;
      r_byte_idx  <= '0;
    end else if (w_pop) begin
      r_unp_valid <= 1'b1;
      r_unp_word  <= w_fifo_data;
      r_byte_idx  <= '0;
    end else if (w_emit) begin
      if (r_byte_idx == 2'd3) r_unp_valid <= 1'b0;
      r_byte_idx <= r_byte_idx + 1'b1;
    end
  end

  // Registered video RAM write port, one cycle behind the byte selection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= w_emit;
      if (w_emit) begin
        wr_addr <= r_pix_cnt;
        wr_data <= gris_a_rgb(w_byte);
      end
    end
  end

endmodule

// File: tb/tb_escritor_framebuffer.sv
// Self-checking bench for escritor_framebuffer (FRAME_PIXELS=16, FIFO_DEPTH=4).
// Builds with or without FB_VBLANK_GATE_EN; the vblank scenario runs only when defined.
module tb_escritor_framebuffer;

  localparam int ADDR_W = 18;
  localparam int FP     = 16;
  localparam int FD     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              busy;
  logic              frame_done;
`ifdef FB_VBLANK_GATE_EN
  logic              vblank;
`endif

  always #5 clk = ~clk;

  escritor_framebuffer #(
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FP),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
`ifdef FB_VBLANK_GATE_EN
    .vblank     (vblank),
`endif
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    int          addr;
    logic [23:0] data;
    int          cyc;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  wr_t         wr_log[$];
  int          fd_log[$];
  logic        fd_busy[$];
  int          acc_cnt;
  int          busy_drops;
  bit          busy_track = 1'b0;
  bit          abort      = 1'b0;
  logic [31:0] tx_words[5];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: records writes, done pulses, accepted words and busy drops.
  always @(negedge clk) begin
    if (wr_en) wr_log.push_back('{int'(wr_addr), wr_data, cyc});
    if (frame_done) begin
      fd_log.push_back(cyc);
      fd_busy.push_back(busy);
    end
    if (in_valid && in_ready) acc_cnt = acc_cnt + 1;
    if (busy_track) begin
      if (frame_done) busy_track = 1'b0;
      else if (!busy) busy_drops = busy_drops + 1;
    end
  end

  // Reference: pixel i of the frame is byte (i mod 4) of word (i / 4), replicated to R,G,B.
  function automatic logic [23:0] exp_pix(input int i);
    logic [31:0] w;
    logic [7:0]  b;
    w = tx_words[i / 4];
    b = w[8 * (i % 4) +: 8];
    return {b, b, b};
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    fd_log.delete();
    fd_busy.delete();
    acc_cnt    = 0;
    busy_drops = 0;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; start is high for exactly one edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic randomize_words(input int n);
    for (int i = 0; i < n; i++) tx_words[i] = $urandom;
  endtask

  // Offer n words in order; in toggle mode in_valid is high 3 cycles, low 3 cycles.
  task automatic feed(input int n, input bit toggle, input int max_cyc, output int acc);
    int  idx;
    int  k;
    bit  taken;
    idx = 0;
    k   = 0;
    while (idx < n && k < max_cyc && !abort) begin
      in_valid = toggle ? (((k / 3) % 2) == 0) : 1'b1;
      in_data  = tx_words[idx];
      @(negedge clk);
      taken = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (taken) idx++;
      k++;
    end
    in_valid = 1'b0;
    acc = idx;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int k;
    k = 0;
    while (fd_log.size() == 0 && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fd_log.size() != 1) begin
      failures++;
      $display("FAIL %s frame_done count: got %0d expected 1", name, fd_log.size());
    end
  endtask

  task automatic check_writes(input string name, input int n, input bit contiguous);
    checks++;
    if (wr_log.size() != n) begin
      failures++;
      $display("FAIL %s write count: got %0d expected %0d", name, wr_log.size(), n);
    end
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i].addr !== i) begin
        failures++;
        $display("FAIL %s addr[%0d]: got %0d expected %0d", name, i, wr_log[i].addr, i);
      end
      checks++;
      if (wr_log[i].data !== exp_pix(i)) begin
        failures++;
        $display("FAIL %s data[%0d]: got %06h expected %06h", name, i, wr_log[i].data, exp_pix(i));
      end
      if (contiguous && i > 0) begin
        checks++;
        if (wr_log[i].cyc != wr_log[i-1].cyc + 1) begin
          failures++;
          $display("FAIL %s gap before write %0d: got cycle %0d expected %0d",
                   name, i, wr_log[i].cyc, wr_log[i-1].cyc + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wr_en, busy, frame_done, in_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset flags: got %b expected 0000", {wr_en, busy, frame_done, in_ready});
    end
    checks++;
    if (wr_addr !== '0) begin
      failures++;
      $display("FAIL reset wr_addr: got %0d expected 0", wr_addr);
    end
    checks++;
    if (wr_data !== '0) begin
      failures++;
      $display("FAIL reset wr_data: got %06h expected 0", wr_data);
    end
    do_reset();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle busy after reset: got %b expected 0", busy);
    end
  endtask

  task automatic test_single_word();
    int acc;
    do_reset();
    clear_logs();
    tx_words[0] = 32'h44332211;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single busy after start: got %b expected 1", busy);
    end
    feed(1, 1'b0, 20, acc);
    repeat (10) @(posedge clk);
    #1;
    check_writes("single", 4, 1'b1);
    checks++;
    if (wr_log.size() == 4 && (wr_log[0].data !== 24'h111111 || wr_log[3].data !== 24'h444444)) begin
      failures++;
      $display("FAIL single literal data: got %06h/%06h expected 111111/444444",
               wr_log[0].data, wr_log[3].data);
    end
  endtask

  task automatic test_stream();
    int acc;
    do_reset();
    clear_logs();
    randomize_words(5);
    pulse_start();
    feed(4, 1'b0, 100, acc);
    // Keep offering an extra word; it must never be taken.
    in_valid = 1'b1;
    in_data  = tx_words[4];
    wait_done("stream", 100);
    check_writes("stream", FP, 1'b1);
    if (fd_log.size() == 1 && wr_log.size() == FP) begin
      checks++;
      if (fd_log[0] != wr_log[FP-1].cyc + 1) begin
        failures++;
        $display("FAIL stream done latency: got cycle %0d expected %0d", fd_log[0], wr_log[FP-1].cyc + 1);
      end
      checks++;
      if (fd_busy[0] !== 1'b0) begin
        failures++;
        $display("FAIL stream busy at done: got %b expected 0", fd_busy[0]);
      end
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stream in_ready after frame: got %b expected 0", in_ready);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cnt != 4) begin
      failures++;
      $display("FAIL stream accepted words: got %0d expected 4", acc_cnt);
    end
  endtask

  task automatic test_toggle();
    int acc;
    do_reset();
    clear_logs();
    randomize_words(4);
    pulse_start();
    busy_track = 1'b1;
    feed(4, 1'b1, 200, acc);
    wait_done("toggle", 200);
    busy_track = 1'b0;
    check_writes("toggle", FP, 1'b0);
    checks++;
    if (busy_drops != 0) begin
      failures++;
      $display("FAIL toggle busy drops: got %0d expected 0", busy_drops);
    end
  endtask

  task automatic test_restart();
    int acc;
    bit seen;
    do_reset();
    clear_logs();
    randomize_words(4);
    pulse_start();
    seen = 1'b0;
    fork
      feed(4, 1'b0, 100, acc);
      begin
        for (int k = 0; k < 100 && !seen; k++) begin
          @(negedge clk);
          if (wr_en && wr_addr == 5) seen = 1'b1;
        end
        if (seen) begin
          @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
    join
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL restart addr 5 seen: got 0 expected 1");
    end
    wait_done("restart", 100);
    check_writes("restart", FP, 1'b1);
  endtask

  task automatic test_abort();
    int acc;
    bit seen;
    do_reset();
    clear_logs();
    randomize_words(4);
    abort = 1'b0;
    pulse_start();
    seen = 1'b0;
    fork
      feed(4, 1'b0, 100, acc);
      begin
        for (int k = 0; k < 100 && !seen; k++) begin
          @(negedge clk);
          #1;
          if (wr_en && wr_addr == 9) seen = 1'b1;
        end
        if (seen) begin
          reset = 1'b0;
          abort = 1'b1;
          #1;
          checks++;
          if (wr_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort immediate: got wr_en=%b busy=%b expected 0 0", wr_en, busy);
          end
        end
      end
    join
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL abort addr 9 seen: got 0 expected 1");
    end
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (wr_log.size() != 10) begin
      failures++;
      $display("FAIL abort writes: got %0d expected 10", wr_log.size());
    end
    checks++;
    if (fd_log.size() != 0) begin
      failures++;
      $display("FAIL abort frame_done: got %0d expected 0", fd_log.size());
    end
    clear_logs();
    randomize_words(4);
    pulse_start();
    feed(4, 1'b0, 100, acc);
    wait_done("abort_restart", 100);
    check_writes("abort_restart", FP, 1'b1);
  endtask

`ifdef FB_VBLANK_GATE_EN
  task automatic test_vblank();
    int acc;
    vblank = 1'b0;
    do_reset();
    clear_logs();
    randomize_words(5);
    pulse_start();
    feed(5, 1'b0, 30, acc);
    checks++;
    if (acc != FD) begin
      failures++;
      $display("FAIL vblank accepted: got %0d expected %0d", acc, FD);
    end
    checks++;
    if (wr_log.size() != 0) begin
      failures++;
      $display("FAIL vblank writes while low: got %0d expected 0", wr_log.size());
    end
    @(posedge clk);
    #1 vblank = 1'b1;
    wait_done("vblank", 100);
    check_writes("vblank", FP, 1'b1);
  endtask
`endif

  initial begin
`ifdef FB_VBLANK_GATE_EN
    vblank = 1'b1;
`endif
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    acc_cnt    = 0;
    busy_drops = 0;
    test_reset();
    test_single_word();
    test_stream();
    test_toggle();
    test_restart();
    test_abort();
`ifdef FB_VBLANK_GATE_EN
    test_vblank();
    vblank = 1'b1;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/escritor_framebuffer.md
Name: escritor_framebuffer

Overview:
- Upstream stage of the VGA controller: drains 32-bit data-memory words from the processor and writes 24-bit RGB pixels into the video RAM, which the VGA controller then scans out.
- Each input word carries 4 grayscale pixels, one byte each. Every byte is expanded to a gray RGB value with R=G=B=byte.
- Writes use a linear address from 0 to FRAME_PIXELS-1. The block pulses frame_done when the frame is complete.

Parameters:
- ADDR_W, 18: width of wr_addr; matches the video RAM address bus.
- FRAME_PIXELS, 65536: pixels per frame (256x256). Must be a multiple of 4 and no greater than 2**ADDR_W.
- FIFO_DEPTH, 4: input word FIFO depth. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle pulse that begins a frame load.
- in_data, input, 32: pixel word. Byte 0 ([7:0]) is the first pixel, byte 3 ([31:24]) is the last.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: the block accepts a word this cycle.
- wr_en, output, 1: video RAM write strobe.
- wr_addr, output, ADDR_W: video RAM write address.
- wr_data, output, 24: {R,G,B}, each equal to the source byte.
- busy, output, 1: high from the cycle after start is accepted until the cycle frame_done pulses.
- frame_done, output, 1: one-cycle pulse after the last pixel is written.

Behaviour:
- Reset (async assert, sync release): all outputs are 0, FIFO is empty, state is IDLE, pixel counter is 0.
- FSM has three states:
  - IDLE: a start pulse moves to RUN and clears the word counter and pixel counter. Start is ignored in any other state.
  - RUN: accept words and emit pixels.
  - FIN: frame_done=1 for one cycle, then IDLE. busy=0 in FIN.
- in_ready = (state==RUN) && FIFO not full && words_accepted < FRAME_PIXELS/4.
- A word is transferred when in_valid && in_ready. Words presented outside RUN are not consumed.
- FIFO rules:
  - Synchronous.
  - Push and pop in the same cycle are both allowed when full: pop frees the slot.
  - Pop when empty does not occur.
- Unpacker:
  - Holds one word plus a 2-bit byte index.
  - When it is empty and the FIFO is non-empty, it loads the head word in one cycle.
  - It then emits bytes 0..3 on 4 consecutive cycles, one pixel per cycle.
  - It may load the next word on the same cycle byte 3 is emitted, so a full FIFO sustains 1 pixel/clk.
- Write port:
  - wr_en, wr_addr and wr_data are registered.
  - One cycle of latency from the unpacker selecting a byte to wr_en=1.
  - wr_addr equals the pixel counter value for that pixel; the counter increments after each emitted pixel.
- Completion:
  - When the pixel with address FRAME_PIXELS-1 is written, the counter wraps to 0 and the state moves to FIN on the next cycle.
  - frame_done asserts exactly 1 cycle after that final wr_en.
- Stall: if the FIFO empties mid-frame, wr_en drops. Address and byte index hold, and there are no gaps in the address sequence.
- Reset asserted mid-frame aborts immediately: no further writes, no frame_done.
- Extra words after FRAME_PIXELS/4 are never accepted, because in_ready stays low.

Optional Feature:
- FB_VBLANK_GATE_EN defined:
  - Adds input port vblank (1 bit).
  - Pixels are emitted only while vblank=1. Otherwise the unpacker holds, wr_en=0, and the FIFO continues to fill until full, then in_ready drops.
  - A vblank fall takes effect the same cycle: no write is issued on a cycle where vblank=0.
- FB_VBLANK_GATE_EN undefined: no vblank port; writes proceed whenever data is available.

Decomposition:
- Package fb_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, FIN} fb_estado_t;
  - localparam PIX_POR_PALABRA = 4;
  - function gris_a_rgb(byte) -> 24 bits.
- Sub-module fifo_palabras(WIDTH=32, DEPTH): synchronous FIFO with push/pop/full/empty, same clk and reset.

Test Plan:
1. Reset, then start; send word 0x44332211 with in_valid held. Required: writes at addr 0,1,2,3 with data 0x111111, 0x222222, 0x333333, 0x444444 on consecutive cycles.
2. FRAME_PIXELS=16: continuous stream of 4 words. Required: 16 writes at addr 0..15 with no gaps, frame_done exactly 1 cycle after addr 15, and in_ready=0 afterwards.
3. FRAME_PIXELS=16: present words with in_valid toggling every 3 cycles. Required: addresses strictly sequential 0..15, no write while the FIFO and unpacker are empty, and busy=1 throughout.
4. Pulse start again mid-frame at addr 5. Required: ignored; the sequence continues at addr 6.
5. Assert reset at addr 9. Required: wr_en=0 immediately, no frame_done; a new start rewrites from addr 0.
6. With FB_VBLANK_GATE_EN, vblank=0 and 5 words offered. Required: 4 accepted (FIFO_DEPTH=4), zero writes. Raise vblank: 16 writes at addr 0..15 follow.
